// File: rtl/cell_burst_injector.sv
// rtl/cell_burst_injector.sv - cell-link interposer that injects bursts of FA packets
//
// Sits between the CCW/CW AXI-Stream TX sources and the Aurora cores. A rising
// edge on fa_strobe starts a burst of burst_len packets on the link chosen by
// out_ccw. The generator waits for an upstream packet boundary, stalls the
// upstream source while it owns the link, honours downstream tready and only
// switches ownership between packets. When idle it is a pure passthrough.
//
// Optional feature: define CELL_BURST_INJECTOR_SEQ_DATA_EN to fill payload
// words with {pkt_sent_cnt, 8'h00, word_index}; otherwise payload is zero.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   fa_strobe                           burst trigger (rising edge)
//   out_ccw                             link select at trigger (1 = CCW, 0 = CW)
//   burst_len[7:0]                      packets per burst, sampled at trigger
//   CELL_CCW_AXI_STREAM_TX_*_in/_out    CCW upstream in / downstream out stream
//   CELL_CW_AXI_STREAM_TX_*_in/_out     CW upstream in / downstream out stream
//   busy                                burst in progress
//   pkt_sent_cnt[15:0]                  packets injected since reset (wraps)
//   strobe_miss                         sticky: trigger seen while busy

module cell_burst_injector #(
  parameter logic [4:0]  CELL_INDEX     = 5'd0,
  parameter int unsigned PKT_SIZE_WORDS = 5,
  parameter logic [15:0] MAGIC          = 16'hA5BE,
  parameter logic [8:0]  FOFB_BASE      = 9'd0,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter logic [31:0] FAKE_CRC       = 32'hADADFACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fa_strobe,
  input  logic        out_ccw,
  input  logic [7:0]  burst_len,

  input  logic [31:0] CELL_CCW_AXI_STREAM_TX_tdata_in,
  input  logic        CELL_CCW_AXI_STREAM_TX_tlast_in,
  input  logic        CELL_CCW_AXI_STREAM_TX_tvalid_in,
  output logic        CELL_CCW_AXI_STREAM_TX_tready_out,
  output logic [31:0] CELL_CCW_AXI_STREAM_TX_tdata_out,
  output logic        CELL_CCW_AXI_STREAM_TX_tlast_out,
  output logic        CELL_CCW_AXI_STREAM_TX_tvalid_out,
  input  logic        CELL_CCW_AXI_STREAM_TX_tready_in,

  input  logic [31:0] CELL_CW_AXI_STREAM_TX_tdata_in,
  input  logic        CELL_CW_AXI_STREAM_TX_tlast_in,
  input  logic        CELL_CW_AXI_STREAM_TX_tvalid_in,
  output logic        CELL_CW_AXI_STREAM_TX_tready_out,
  output logic [31:0] CELL_CW_AXI_STREAM_TX_tdata_out,
  output logic        CELL_CW_AXI_STREAM_TX_tlast_out,
  output logic        CELL_CW_AXI_STREAM_TX_tvalid_out,
  input  logic        CELL_CW_AXI_STREAM_TX_tready_in,

  output logic        busy,
  output logic [15:0] pkt_sent_cnt,
  output logic        strobe_miss
);

  localparam logic [7:0]  LAST_WORD = 8'(PKT_SIZE_WORDS - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BOUNDARY,
    SEND,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic        sel_ccw_q, sel_ccw_d;
  logic [7:0]  burst_len_q, burst_len_d;
  logic [7:0]  pkt_idx_q, pkt_idx_d;
  logic [7:0]  word_q, word_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        miss_q, miss_d;
  logic        strobe_q;
  logic        in_pkt_ccw_q, in_pkt_ccw_d;
  logic        in_pkt_cw_q, in_pkt_cw_d;

  logic        strobe_rise;
  logic        sel_in_pkt;
  logic        sel_tready;
  logic        override;
  logic        decide;
  logic        take_ccw;
  logic        take_cw;
  logic        last_word;
  logic [8:0]  fofb;
  logic [31:0] gen_tdata;
  logic        ccw_beat;
  logic        cw_beat;

  assign strobe_rise = fa_strobe & ~strobe_q;
  assign sel_in_pkt  = sel_ccw_q ? in_pkt_ccw_q : in_pkt_cw_q;
  assign sel_tready  = sel_ccw_q ? CELL_CCW_AXI_STREAM_TX_tready_in
                                 : CELL_CW_AXI_STREAM_TX_tready_in;
  assign override    = (state_q == SEND);

  // Cycle in which the link is claimed at a packet boundary. Upstream is
  // already held off here so no new upstream packet can start on the very
  // edge where the generator takes over.
  assign decide = ~sel_in_pkt &
                  ((state_q == WAIT_BOUNDARY) ||
                   ((state_q == GAP) && (gap_cnt_q == GAP_LAST)));

  assign take_ccw  = (override | decide) & sel_ccw_q;
  assign take_cw   = (override | decide) & ~sel_ccw_q;
  assign last_word = (word_q == LAST_WORD);
  assign fofb      = FOFB_BASE + {1'b0, pkt_idx_q};

  always_comb begin
    gen_tdata = 32'h0;
    if (word_q == 8'd0) begin
      gen_tdata = {MAGIC, 1'b1, CELL_INDEX, 1'b0, fofb};
    end else if (last_word) begin
      gen_tdata = FAKE_CRC;
    end else begin
`ifdef CELL_BURST_INJECTOR_SEQ_DATA_EN
      gen_tdata = {pkt_cnt_q, 8'h00, word_q};
`else
      gen_tdata = 32'h0;
`endif
    end
  end

  // Link output muxes: generator while owning the link, passthrough otherwise.
  assign CELL_CCW_AXI_STREAM_TX_tdata_out  = take_ccw ? gen_tdata : CELL_CCW_AXI_STREAM_TX_tdata_in;
  assign CELL_CCW_AXI_STREAM_TX_tlast_out  = take_ccw ? last_word : CELL_CCW_AXI_STREAM_TX_tlast_in;
  assign CELL_CCW_AXI_STREAM_TX_tvalid_out = take_ccw ? override  : CELL_CCW_AXI_STREAM_TX_tvalid_in;
  assign CELL_CCW_AXI_STREAM_TX_tready_out = take_ccw ? 1'b0      : CELL_CCW_AXI_STREAM_TX_tready_in;

  assign CELL_CW_AXI_STREAM_TX_tdata_out   = take_cw ? gen_tdata : CELL_CW_AXI_STREAM_TX_tdata_in;
  assign CELL_CW_AXI_STREAM_TX_tlast_out   = take_cw ? last_word : CELL_CW_AXI_STREAM_TX_tlast_in;
  assign CELL_CW_AXI_STREAM_TX_tvalid_out  = take_cw ? override  : CELL_CW_AXI_STREAM_TX_tvalid_in;
  assign CELL_CW_AXI_STREAM_TX_tready_out  = take_cw ? 1'b0      : CELL_CW_AXI_STREAM_TX_tready_in;

  assign ccw_beat = CELL_CCW_AXI_STREAM_TX_tvalid_in & CELL_CCW_AXI_STREAM_TX_tready_out;
  assign cw_beat  = CELL_CW_AXI_STREAM_TX_tvalid_in & CELL_CW_AXI_STREAM_TX_tready_out;

  assign busy         = (state_q != IDLE);
  assign pkt_sent_cnt = pkt_cnt_q;
  assign strobe_miss  = miss_q;

  always_comb begin
    in_pkt_ccw_d = in_pkt_ccw_q;
    in_pkt_cw_d  = in_pkt_cw_q;
    if (ccw_beat) in_pkt_ccw_d = ~CELL_CCW_AXI_STREAM_TX_tlast_in;
    if (cw_beat)  in_pkt_cw_d  = ~CELL_CW_AXI_STREAM_TX_tlast_in;
  end

  always_comb begin
    state_d     = state_q;
    sel_ccw_d   = sel_ccw_q;
    burst_len_d = burst_len_q;
    pkt_idx_d   = pkt_idx_q;
    word_d      = word_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    miss_d      = miss_q | (strobe_rise & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (strobe_rise && (burst_len != 8'd0)) begin
          sel_ccw_d   = out_ccw;
          burst_len_d = burst_len;
          pkt_idx_d   = 8'd0;
          word_d      = 8'd0;
          state_d     = WAIT_BOUNDARY;
        end
      end
      WAIT_BOUNDARY: begin
        if (decide) state_d = SEND;
      end
      SEND: begin
        if (sel_tready) begin
          if (last_word) begin
            word_d    = 8'd0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            pkt_idx_d = pkt_idx_q + 8'd1;
            if ((pkt_idx_q + 8'd1) == burst_len_q) begin
              state_d = IDLE;
            end else if (GAP_CYCLES > 0) begin
              gap_cnt_d = 16'd0;
              state_d   = GAP;
            end
          end else begin
            word_d = word_q + 8'd1;
          end
        end
      end
      GAP: begin
        // The final gap cycle doubles as the boundary check so the idle
        // spacing between packets is exactly GAP_CYCLES.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = decide ? SEND : WAIT_BOUNDARY;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_ccw_q    <= 1'b0;
      burst_len_q  <= 8'd0;
      pkt_idx_q    <= 8'd0;
      word_q       <= 8'd0;
      gap_cnt_q    <= 16'd0;
      pkt_cnt_q    <= 16'd0;
      miss_q       <= 1'b0;
      strobe_q     <= 1'b0;
      in_pkt_ccw_q <= 1'b0;
      in_pkt_cw_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_ccw_q    <= sel_ccw_d;
      burst_len_q  <= burst_len_d;
      pkt_idx_q    <= pkt_idx_d;
      word_q       <= word_d;
      gap_cnt_q    <= gap_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      miss_q       <= miss_d;
      strobe_q     <= fa_strobe;
      in_pkt_ccw_q <= in_pkt_ccw_d;
      in_pkt_cw_q  <= in_pkt_cw_d;
    end
  end

endmodule

// File: tb/tb_cell_burst_injector.sv
// tb/tb_cell_burst_injector.sv - scoreboard bench for cell_burst_injector
module tb_cell_burst_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fa_strobe, out_ccw;
  logic [7:0]  burst_len;
  logic [31:0] ccw_di, cw_di, ccw_do, cw_do;
  logic        ccw_li, cw_li, ccw_vi, cw_vi, ccw_lo, cw_lo, ccw_vo, cw_vo;
  logic        ccw_ro, cw_ro, ccw_ri, cw_ri;
  logic        busy, miss;
  logic [15:0] pkt_cnt;

  logic        b_strobe;
  logic [7:0]  b_len;
  logic [31:0] b_do, b_cw_do;
  logic        b_lo, b_vo, b_ro, b_cw_lo, b_cw_vo, b_cw_ro, b_busy, b_miss;
  logic [15:0] b_cnt;

  cell_burst_injector dut (
    .clk(clk), .rst_n(rst_n), .fa_strobe(fa_strobe), .out_ccw(out_ccw), .burst_len(burst_len),
    .CELL_CCW_AXI_STREAM_TX_tdata_in(ccw_di), .CELL_CCW_AXI_STREAM_TX_tlast_in(ccw_li),
    .CELL_CCW_AXI_STREAM_TX_tvalid_in(ccw_vi), .CELL_CCW_AXI_STREAM_TX_tready_out(ccw_ro),
    .CELL_CCW_AXI_STREAM_TX_tdata_out(ccw_do), .CELL_CCW_AXI_STREAM_TX_tlast_out(ccw_lo),
    .CELL_CCW_AXI_STREAM_TX_tvalid_out(ccw_vo), .CELL_CCW_AXI_STREAM_TX_tready_in(ccw_ri),
    .CELL_CW_AXI_STREAM_TX_tdata_in(cw_di), .CELL_CW_AXI_STREAM_TX_tlast_in(cw_li),
    .CELL_CW_AXI_STREAM_TX_tvalid_in(cw_vi), .CELL_CW_AXI_STREAM_TX_tready_out(cw_ro),
    .CELL_CW_AXI_STREAM_TX_tdata_out(cw_do), .CELL_CW_AXI_STREAM_TX_tlast_out(cw_lo),
    .CELL_CW_AXI_STREAM_TX_tvalid_out(cw_vo), .CELL_CW_AXI_STREAM_TX_tready_in(cw_ri),
    .busy(busy), .pkt_sent_cnt(pkt_cnt), .strobe_miss(miss)
  );

  cell_burst_injector #(.FOFB_BASE(9'd511), .GAP_CYCLES(4)) dut_gap (
    .clk(clk), .rst_n(rst_n), .fa_strobe(b_strobe), .out_ccw(1'b1), .burst_len(b_len),
    .CELL_CCW_AXI_STREAM_TX_tdata_in(32'h0), .CELL_CCW_AXI_STREAM_TX_tlast_in(1'b0),
    .CELL_CCW_AXI_STREAM_TX_tvalid_in(1'b0), .CELL_CCW_AXI_STREAM_TX_tready_out(b_ro),
    .CELL_CCW_AXI_STREAM_TX_tdata_out(b_do), .CELL_CCW_AXI_STREAM_TX_tlast_out(b_lo),
    .CELL_CCW_AXI_STREAM_TX_tvalid_out(b_vo), .CELL_CCW_AXI_STREAM_TX_tready_in(1'b1),
    .CELL_CW_AXI_STREAM_TX_tdata_in(32'h0), .CELL_CW_AXI_STREAM_TX_tlast_in(1'b0),
    .CELL_CW_AXI_STREAM_TX_tvalid_in(1'b0), .CELL_CW_AXI_STREAM_TX_tready_out(b_cw_ro),
    .CELL_CW_AXI_STREAM_TX_tdata_out(b_cw_do), .CELL_CW_AXI_STREAM_TX_tlast_out(b_cw_lo),
    .CELL_CW_AXI_STREAM_TX_tvalid_out(b_cw_vo), .CELL_CW_AXI_STREAM_TX_tready_in(1'b1),
    .busy(b_busy), .pkt_sent_cnt(b_cnt), .strobe_miss(b_miss)
  );

  // {tlast, tdata} per beat
  logic [32:0] exp_ccw[$], exp_cw[$], exp_b[$], src_ccw[$], src_cw[$];
  int          checks = 0;
  int          errors = 0;
  bit          bp_ccw = 1'b0;
  bit          hold_ccw = 1'b0;
  logic [32:0] hold_word;
  bit          b_armed = 1'b0;
  bit          b_gap_seen = 1'b0;
  int          b_idle = 0;
  int          src_cw_sent = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected injected packets: header, payload, CRC for each packet of a burst.
  task automatic push_burst(input bit ccw, input int n, input logic [8:0] base,
                            input logic [15:0] cnt0, input bit to_b);
    logic [32:0] w;
    logic [8:0]  f;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 5; i++) begin
        f = base + 9'(p);
        if (i == 0)      w = {1'b0, 16'hA5BE, 1'b1, 5'd0, 1'b0, f};
        else if (i == 4) w = {1'b1, 32'hADADFACE};
`ifdef CELL_BURST_INJECTOR_SEQ_DATA_EN
        else             w = {1'b0, cnt0 + 16'(p), 8'h00, 8'(i)};
`else
        else             w = {1'b0, 32'h0};
`endif
        if (to_b)     exp_b.push_back(w);
        else if (ccw) exp_ccw.push_back(w);
        else          exp_cw.push_back(w);
      end
    end
  endtask

  // Upstream packet: queued at the source and expected unchanged downstream.
  task automatic up_pkt(input bit ccw, input logic [31:0] base);
    logic [32:0] w;
    for (int i = 0; i < 5; i++) begin
      w = {(i == 4), base + 32'(i)};
      if (ccw) begin src_ccw.push_back(w); exp_ccw.push_back(w); end
      else     begin src_cw.push_back(w);  exp_cw.push_back(w);  end
    end
  endtask

  task automatic tick();
    bit acc_ccw, acc_cw;
    @(negedge clk);
    acc_ccw = ccw_vi && ccw_ro;
    acc_cw  = cw_vi && cw_ro;
    if (acc_cw) src_cw_sent++;
    if (hold_ccw) chk("ccw_hold_stable", 64'({ccw_vo, ccw_lo, ccw_do}), 64'({1'b1, hold_word}));
    hold_ccw  = ccw_vo && !ccw_ri;
    hold_word = {ccw_lo, ccw_do};
    if (ccw_vo && ccw_ri) begin
      if (exp_ccw.size() == 0) chk("ccw_extra_beat", 64'(ccw_vo), 64'd0);
      else chk("ccw_beat", 64'({ccw_lo, ccw_do}), 64'(exp_ccw.pop_front()));
    end
    if (cw_vo && cw_ri) begin
      if (exp_cw.size() == 0) chk("cw_extra_beat", 64'(cw_vo), 64'd0);
      else chk("cw_beat", 64'({cw_lo, cw_do}), 64'(exp_cw.pop_front()));
    end
    if (b_vo) begin
      if (exp_b.size() == 0) chk("gap_extra_beat", 64'(b_vo), 64'd0);
      else chk("gap_beat", 64'({b_lo, b_do}), 64'(exp_b.pop_front()));
      if (b_armed) begin
        chk("gap_cycles", 64'(b_idle), 64'd4);
        b_armed    = 1'b0;
        b_gap_seen = 1'b1;
      end
      if (b_lo) begin b_armed = 1'b1; b_idle = 0; end
    end else if (b_armed) begin
      b_idle++;
    end
    @(posedge clk);
    #1;
    if (acc_ccw) void'(src_ccw.pop_front());
    if (acc_cw)  void'(src_cw.pop_front());
    ccw_vi = (src_ccw.size() > 0);
    if (ccw_vi) {ccw_li, ccw_di} = src_ccw[0]; else {ccw_li, ccw_di} = 33'h0;
    cw_vi = (src_cw.size() > 0);
    if (cw_vi) {cw_li, cw_di} = src_cw[0]; else {cw_li, cw_di} = 33'h0;
    if (bp_ccw) ccw_ri = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input bit ccw, input logic [7:0] len);
    out_ccw   = ccw;
    burst_len = len;
    fa_strobe = 1'b1;
    tick();
    fa_strobe = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((busy || b_busy || exp_ccw.size() > 0 || exp_cw.size() > 0 || exp_b.size() > 0 ||
            src_ccw.size() > 0 || src_cw.size() > 0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < max), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; fa_strobe = 1'b0; out_ccw = 1'b0; burst_len = 8'd0;
    ccw_di = 32'h0; ccw_li = 1'b0; ccw_vi = 1'b0; ccw_ri = 1'b1;
    cw_di = 32'h0; cw_li = 1'b0; cw_vi = 1'b0; cw_ri = 1'b1;
    b_strobe = 1'b0; b_len = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and passthrough
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_miss", 64'(miss), 64'd0);
    chk("rst_ccw_tready", 64'(ccw_ro), 64'd1);
    cw_ri = 1'b0;
    cw_di = 32'hCAFE0001;
    #1;
    chk("rst_cw_tready", 64'(cw_ro), 64'd0);
    chk("rst_cw_tdata", 64'(cw_do), 64'hCAFE0001);
    cw_ri = 1'b1;
    tick();

    // Basic burst on CCW, CW carries an upstream packet untouched
    up_pkt(1'b0, 32'h1000_0000);
    push_burst(1'b1, 3, 9'd0, 16'd0, 1'b0);
    pulse(1'b1, 8'd3);
    drain(300);
    chk("basic_cnt", 64'(pkt_cnt), 64'd3);
    chk("basic_busy", 64'(busy), 64'd0);

    // Strobe held high triggers once
    push_burst(1'b1, 1, 9'd0, 16'd3, 1'b0);
    out_ccw = 1'b1; burst_len = 8'd1; fa_strobe = 1'b1;
    repeat (30) tick();
    fa_strobe = 1'b0;
    drain(300);
    chk("hold_cnt", 64'(pkt_cnt), 64'd4);
    chk("hold_no_miss", 64'(miss), 64'd0);

    // Backpressure on CCW
    bp_ccw = 1'b1;
    push_burst(1'b1, 3, 9'd0, 16'd4, 1'b0);
    pulse(1'b1, 8'd3);
    drain(1000);
    bp_ccw = 1'b0;
    ccw_ri = 1'b1;
    chk("bp_cnt", 64'(pkt_cnt), 64'd7);

    // Boundary wait: CW upstream mid-packet when the strobe arrives
    src_cw_sent = 0;
    up_pkt(1'b0, 32'h2000_0000);
    n = 0;
    while (src_cw_sent < 2 && n < 50) begin tick(); n++; end
    chk("bnd_start_in_time", 64'(n < 50), 64'd1);
    push_burst(1'b0, 2, 9'd0, 16'd7, 1'b0);
    pulse(1'b0, 8'd2);
    up_pkt(1'b0, 32'h3000_0000);
    n = 0;
    while (src_cw.size() > 5 && n < 50) begin tick(); n++; end
    chk("bnd_tlast_in_time", 64'(n < 50), 64'd1);
    chk("bnd_busy", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 100) begin
      chk("bnd_stall", 64'(cw_ro), 64'd0);
      tick();
      n++;
    end
    drain(300);
    chk("bnd_cnt", 64'(pkt_cnt), 64'd9);

    // Strobe while busy, then zero-length strobe
    push_burst(1'b1, 2, 9'd0, 16'd9, 1'b0);
    pulse(1'b1, 8'd2);
    repeat (3) tick();
    chk("miss_busy", 64'(busy), 64'd1);
    pulse(1'b1, 8'd7);
    chk("miss_set", 64'(miss), 64'd1);
    drain(300);
    chk("miss_cnt", 64'(pkt_cnt), 64'd11);
    pulse(1'b1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("zero_busy", 64'(busy), 64'd0);
      tick();
    end
    chk("zero_cnt", 64'(pkt_cnt), 64'd11);

    // Reset during word 2 of a burst
    push_burst(1'b1, 3, 9'd0, 16'd11, 1'b0);
    pulse(1'b1, 8'd3);
    n = 0;
    while (exp_ccw.size() > 13 && n < 50) begin tick(); n++; end
    chk("rst_mid_in_time", 64'(n < 50), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(ccw_vo), 64'd0);
    chk("rst_mid_tready", 64'(ccw_ro), 64'd1);
    chk("rst_mid_tdata", 64'(ccw_do), 64'(ccw_di));
    chk("rst_mid_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    exp_ccw.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_burst(1'b1, 1, 9'd0, 16'd0, 1'b0);
    pulse(1'b1, 8'd1);
    drain(300);
    chk("post_rst_cnt", 64'(pkt_cnt), 64'd1);
    chk("post_rst_miss", 64'(miss), 64'd0);

    // Gap spacing and FOFB wrap on the second instance
    b_armed = 1'b0;
    b_gap_seen = 1'b0;
    push_burst(1'b1, 2, 9'd511, 16'd0, 1'b1);
    b_len = 8'd2;
    b_strobe = 1'b1;
    tick();
    b_strobe = 1'b0;
    drain(300);
    chk("gap_cnt", 64'(b_cnt), 64'd2);
    chk("gap_seen", 64'(b_gap_seen), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_burst_injector.md
Name: cell_burst_injector

Overview:
- Parametrised next-generation cell-link interposer and traffic generator for simulation and bench testing.
- Sits between the cell controller's CCW/CW AXI-Stream TX sources and the Aurora cores.
- On each rising edge of fa_strobe it injects a burst of burst_len FA packets on one link. Each packet has an incrementing FOFB index.
- Unlike the single-shot generator, it honours tready, switches only at packet boundaries, and stalls upstream traffic instead of corrupting it. Otherwise the interposer is transparent.

Parameters:
- CELL_INDEX, 0: 5-bit cell index placed in every header.
- PKT_SIZE_WORDS, 5: words per packet including header and CRC; legal range 3..255.
- MAGIC, 16'hA5BE: header magic field.
- FOFB_BASE, 0: 9-bit FOFB index of the first packet in a burst.
- GAP_CYCLES, 0: idle cycles between packets inside a burst, during which the override is released.
- FAKE_CRC, 32'hADADFACE: constant final word.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- fa_strobe  in  1  burst trigger; rising edge detected internally.
- out_ccw  in  1  link select, sampled at trigger: 1 = CCW, 0 = CW.
- burst_len  in  8  packets per burst, sampled at trigger.
- CELL_CCW_AXI_STREAM_TX_{tdata,tlast,tvalid}_in  in  32/1/1  upstream CCW stream.
- CELL_CCW_AXI_STREAM_TX_tready_out  out  1  ready to upstream CCW.
- CELL_CCW_AXI_STREAM_TX_{tdata,tlast,tvalid}_out  out  32/1/1  downstream CCW stream.
- CELL_CCW_AXI_STREAM_TX_tready_in  in  1  ready from downstream CCW.
- CELL_CW_*: the same eight signals for the CW link.
- busy  out  1  burst in progress.
- pkt_sent_cnt  out  16  total packets injected since reset; wraps.
- strobe_miss  out  1  sticky flag, cleared only by reset.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; override=0, tvalid=0, busy=0, pkt_sent_cnt=0, strobe_miss=0, both in_pkt flags=0.
  - All _out ports are then a pure passthrough of their _in counterparts.
  - tready_out equals the corresponding downstream tready_in.
  - Reset mid-packet abandons the packet; no tlast is emitted.
- Boundary tracking, per link:
  - in_pkt is set on an upstream beat (tvalid&tready) with tlast=0.
  - in_pkt is cleared on a beat with tlast=1.
- IDLE:
  - Rising edge with burst_len!=0: latch out_ccw and burst_len, clear pkt_idx, set busy, go to WAIT_BOUNDARY.
  - Rising edge with burst_len==0: ignored; busy stays 0.
- WAIT_BOUNDARY: on the first cycle the selected link's in_pkt==0, set override and go to SEND.
  - The in_pkt value sampled is the registered value, which already includes any tlast beat accepted on the previous edge.
- Override active on the selected link:
  - _out ports are driven by the generator.
  - tready_out to upstream is 0, so upstream stalls and no data is lost.
  - The non-selected link stays passthrough.
- SEND, word w = 0..PKT_SIZE_WORDS-1, one word per accepted beat:
  - tvalid=1. tdata/tlast stay stable until tvalid&tready_in.
  - The first word is valid the cycle after entering SEND.
  - With tready held at 1, a packet takes PKT_SIZE_WORDS consecutive cycles.
  - w=0: {MAGIC, 1'b1, CELL_INDEX, 1'b0, fofb}, where fofb = (FOFB_BASE + pkt_idx) mod 512; 9-bit wrap.
  - w=1..PKT_SIZE_WORDS-2: 32'h0 (see Optional Feature).
  - w=last: FAKE_CRC, with tlast=1.
- On acceptance of the last word:
  - pkt_sent_cnt increments and pkt_idx increments.
  - If pkt_idx+1 == burst_len: tvalid=0, override=0, busy=0, go to IDLE.
  - Else if GAP_CYCLES>0: override=0, go to GAP.
  - Else: stay in SEND with override held and start the next header on the next cycle, with no bubble.
- GAP: counts GAP_CYCLES cycles of passthrough, then goes to WAIT_BOUNDARY.
- Rising edge while busy: ignored and sets strobe_miss. A burst is never restarted or extended.
- fa_strobe held high: this is one edge and triggers only once.

Optional Feature:
- Macro CELL_BURST_INJECTOR_SEQ_DATA_EN.
- Defined: payload word w (1..PKT_SIZE_WORDS-2) = {pkt_sent_cnt[15:0], 8'h00, w[7:0]}. The pkt_sent_cnt value used is the one before increment.
- Undefined: payload words are 32'h0 and no extra logic is built.

Test Plan:
- Basic burst: reset, out_ccw=1, burst_len=3, tready=1, fa_strobe pulse.
  - CCW shows 15 beats: headers A5BE8000, A5BE8001, A5BE8002 (CELL_INDEX=0). Each packet's last word is ADADFACE with tlast.
  - pkt_sent_cnt=3, busy falls after the last beat, CW stays pure passthrough.
- Backpressure: toggle CCW tready_in at 50%.
  - Every word is held stable while tvalid&!tready. Word order and count match the basic case.
- Boundary wait: upstream CW is mid-packet (2 of 5 beats sent) when a strobe with out_ccw=0 arrives.
  - The upstream packet completes intact. The injected header appears only after the upstream tlast beat.
  - Upstream tready_out stays 0 until the burst ends.
- Gap and FOFB wrap: GAP_CYCLES=4, FOFB_BASE=511, burst_len=2.
  - Headers carry FOFB indices 511 then 0.
  - Exactly 4 passthrough cycles separate the two packets.
- Miss and zero-length: a strobe while busy sets strobe_miss=1 and leaves burst_len unchanged. A strobe with burst_len=0 gives no output and busy=0.
- Reset mid-burst: assert rst_n=0 during word 2.
  - Outputs are passthrough immediately, pkt_sent_cnt=0.
  - A new strobe after release starts cleanly from FOFB_BASE.
